// File: rtl/rx_word_packer_pkg.sv
// Shared constants and FSM encoding for the receive-side word packer.
package rx_word_packer_pkg;

  localparam int unsigned DEF_DBIT       = 8;
  localparam int unsigned DEF_WORD_BYTES = 4;
  localparam int unsigned DEF_FIFO_W     = 2;
  localparam int unsigned DEF_TO_CYCLES  = 50000;
  localparam int unsigned DEF_TO_BIT     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/rx_word_packer_fifo.sv
// Synchronous byte FIFO; full/empty are registered and derived from pointers with an extra wrap bit.
module rx_word_packer_fifo #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH = 1 << W;

  logic [B-1:0] mem_q [DEPTH];
  logic [W:0]   wr_ptr_q, wr_ptr_d;
  logic [W:0]   rd_ptr_q, rd_ptr_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         wr_en;
  logic         rd_en;

  // Qualify requests and compute next pointers and flags.
  always_comb begin
    rd_en    = rd && !empty_q;
    wr_en    = wr && (!full_q || rd_en);
    wr_ptr_d = wr_ptr_q + (W+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (W+1)'(rd_en);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[W] != rd_ptr_d[W]) && (wr_ptr_d[W-1:0] == rd_ptr_d[W-1:0]);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[W-1:0]] <= w_data;
  end

  assign r_data = mem_q[rd_ptr_q[W-1:0]];
  assign full   = full_q;
  assign empty  = empty_q;

endmodule

// File: rtl/rx_word_packer.sv
// Buffers UART bytes, packs WORD_BYTES of them into a word offered on valid/ready,
// drops stale partial words after an inter-byte timeout and flags FIFO overruns.
module rx_word_packer
  import rx_word_packer_pkg::*;
#(
  parameter int unsigned DBIT       = DEF_DBIT,
  parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
  parameter int unsigned FIFO_W     = DEF_FIFO_W,
  parameter int unsigned TO_CYCLES  = DEF_TO_CYCLES,
  parameter int unsigned TO_BIT     = DEF_TO_BIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_done_tick,
  input  logic [DBIT-1:0]            rx_data,
  input  logic                       word_ready,
  output logic                       word_valid,
  output logic [DBIT*WORD_BYTES-1:0] word_data,
  output logic                       fifo_full,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output logic                       resync
);

  localparam int unsigned WORD_W = DBIT * WORD_BYTES;
  localparam int unsigned CNT_W  = $clog2(WORD_BYTES + 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_BIT-1:0]   to_q, to_d;
  logic                word_valid_q, word_valid_d;
  logic [WORD_W-1:0]   word_data_q, word_data_d;
  logic                overrun_q, overrun_d;
  logic                resync_q, resync_d;

  logic                fifo_empty;
  logic                fifo_full_w;
  logic [DBIT-1:0]     fifo_rd_data;
  logic                pop;
  logic                push;
  logic                drop;
  logic [WORD_W-1:0]   sr_shift;

  rx_word_packer_fifo #(.B(DBIT), .W(FIFO_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr     (push),
    .rd     (pop),
    .w_data (rx_data),
    .r_data (fifo_rd_data),
    .full   (fifo_full_w),
    .empty  (fifo_empty)
  );

  // FIFO handshake: a push into a full FIFO is only legal alongside a pop.
  always_comb begin
    pop      = !fifo_empty && (state_q != HOLD);
    push     = rx_done_tick && (!fifo_full_w || pop);
    drop     = rx_done_tick && !push;
    sr_shift = {sr_q[WORD_W-DBIT-1:0], fifo_rd_data};
  end

  // Next-state: packing FSM, timeout, output word and sticky overrun.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    to_d         = '0;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    resync_d     = 1'b0;
    overrun_d    = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          sr_d    = sr_shift;
          cnt_d   = CNT_W'(1);
          state_d = PACK;
        end
      end
      PACK: begin
        if (pop) begin
          sr_d = sr_shift;
          if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
            word_data_d  = sr_shift;
            word_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (to_q == TO_BIT'(TO_CYCLES - 1)) begin
          // Stale partial word: discard so later words stay aligned.
          sr_d     = '0;
          cnt_d    = '0;
          state_d  = IDLE;
          resync_d = 1'b1;
        end else begin
          to_d = to_q + TO_BIT'(1);
        end
      end
      HOLD: begin
        if (word_valid_q && word_ready) begin
          word_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      overrun_q    <= 1'b0;
      resync_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      overrun_q    <= overrun_d;
      resync_q     <= resync_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign fifo_full  = fifo_full_w;
  assign overrun    = overrun_q;
  assign resync     = resync_q;

endmodule

// File: tb/tb_rx_word_packer.sv
// Bench for rx_word_packer: queue-based reference model compared every cycle, plus directed literals.
module tb_rx_word_packer;

  localparam int TO_CYC = 50000;
  localparam int WB     = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        word_ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic        fifo_full;
  logic        overrun;
  logic        clr_overrun;
  logic        resync;

  int n_pass  = 0;
  int n_total = 0;

  rx_word_packer #(
    .DBIT(8), .WORD_BYTES(4), .FIFO_W(2), .TO_CYCLES(TO_CYC), .TO_BIT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .word_ready   (word_ready),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .fifo_full    (fifo_full),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .resync       (resync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: byte queue, partial-word list, held word, idle-since-pop counter.
  logic [7:0]  mq[$];
  logic [7:0]  part[$];
  logic        m_hold  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_word  = '0;
  logic        m_ovr   = 1'b0;
  logic        m_res   = 1'b0;
  int          since   = 0;
  logic        m_pop, m_full_before, m_accept;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete(); part.delete();
      m_hold = 0; m_valid = 0; m_word = '0; m_ovr = 0; m_res = 0; since = 0;
    end else begin
      m_pop         = (mq.size() != 0) && !m_hold;
      m_full_before = (mq.size() == DEPTH);
      m_accept      = rx_done_tick && (!m_full_before || m_pop);
      m_res         = 0;
      if (m_hold && word_ready) begin
        m_hold = 0; m_valid = 0;
      end
      if (m_pop) begin
        part.push_back(mq.pop_front());
        since = 0;
        if (part.size() == WB) begin
          m_word = '0;
          foreach (part[i]) m_word = (m_word << 8) | 32'(part[i]);
          m_valid = 1; m_hold = 1;
          part.delete();
        end
      end else if (part.size() != 0) begin
        since++;
        if (since == TO_CYC) begin
          part.delete(); since = 0; m_res = 1;
        end
      end
      if (m_accept) mq.push_back(rx_data);
      if (rx_done_tick && !m_accept) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
    end
  end

  // Per-cycle comparison against the model, and log of words the DUT hands over.
  logic [31:0] dut_acc[$];
  always @(negedge clk) begin
    chk("cyc_word_valid", 32'(word_valid), 32'(m_valid));
    chk("cyc_fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
    chk("cyc_resync", 32'(resync), 32'(m_res));
    if (m_valid) chk("cyc_word_data", word_data, m_word);
    if (word_valid && word_ready) dut_acc.push_back(word_data);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!word_valid && n < budget) begin step(); n++; end
    if (!word_valid) chk("wait_valid_timeout", 32'(word_valid), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  logic [7:0]  sent[$];
  logic [31:0] w;
  int          nres, nval;

  initial begin
    rst = 0; rx_done_tick = 0; rx_data = '0; word_ready = 0; clr_overrun = 0;
    repeat (3) step();
    rst = 1;
    step();
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data", word_data, 32'h0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);

    // 1: simple word, two-cycle latency after the last tick
    word_ready = 1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t1_valid_early", 32'(word_valid), 32'd0);
    step();
    chk("t1_valid", 32'(word_valid), 32'd1);
    chk("t1_data", word_data, 32'h11223344);
    step();
    chk("t1_valid_pulse", 32'(word_valid), 32'd0);
    chk("t1_overrun", 32'(overrun), 32'd0);

    // 2: consumer stalls, FIFO fills, fifth byte dropped
    word_ready = 0;
    send(8'h44); send(8'h55); send(8'h66); send(8'h77);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("t2_full", 32'(fifo_full), 32'd1);
    chk("t2_hold_data", word_data, 32'h44556677);
    send(8'hEE);
    chk("t2_overrun", 32'(overrun), 32'd1);
    chk("t2_hold_valid", 32'(word_valid), 32'd1);
    chk("t2_hold_data2", word_data, 32'h44556677);
    word_ready = 1;
    step();
    wait_valid(20);
    chk("t2_second_word", word_data, 32'hAABBCCDD);
    step();
    clr_overrun = 1; step(); clr_overrun = 0;
    chk("t2_clr_overrun", 32'(overrun), 32'd0);

    // 3: partial word times out, then a clean word
    send(8'h01); send(8'h02);
    nres = 0; nval = 0;
    for (int i = 0; i < TO_CYC + 20; i++) begin
      step();
      if (resync) nres++;
      if (word_valid) nval++;
    end
    chk("t3_resync_count", 32'(nres), 32'd1);
    chk("t3_no_word", 32'(nval), 32'd0);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    wait_valid(20);
    chk("t3_word", word_data, 32'h10203040);
    step();

    // 4: push on a full FIFO with a same-cycle pop; drop wins over clear
    word_ready = 0;
    send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
    send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
    chk("t4_full", 32'(fifo_full), 32'd1);
    word_ready = 1;
    step();
    chk("t4_b_accepted", 32'(word_valid), 32'd0);
    word_ready = 0;
    send(8'h5A);
    chk("t4_push_pop_no_overrun", 32'(overrun), 32'd0);
    chk("t4_still_full", 32'(fifo_full), 32'd1);
    wait_valid(20);
    chk("t4_word_c", word_data, 32'hC0C1C2C3);
    send(8'hD0); send(8'hD1); send(8'hD2);
    chk("t4_full_again", 32'(fifo_full), 32'd1);
    clr_overrun = 1;
    send(8'hD3);
    clr_overrun = 0;
    chk("t4_drop_beats_clear", 32'(overrun), 32'd1);
    clr_overrun = 1; step(); clr_overrun = 0;
    chk("t4_cleared", 32'(overrun), 32'd0);
    word_ready = 1;
    step();
    wait_valid(20);
    chk("t4_word_5a", word_data, 32'h5AD0D1D2);
    step();

    // 5: reset in the middle of a word
    send(8'hE1); send(8'hE2); send(8'hE3);
    step();
    rst = 0;
    #1;
    chk("t5_rst_valid", 32'(word_valid), 32'd0);
    chk("t5_rst_data", word_data, 32'h0);
    chk("t5_rst_full", 32'(fifo_full), 32'd0);
    chk("t5_rst_overrun", 32'(overrun), 32'd0);
    chk("t5_rst_resync", 32'(resync), 32'd0);
    repeat (2) step();
    rst = 1;
    step();
    send(8'hF1); send(8'hF2); send(8'hF3); send(8'hF4);
    wait_valid(20);
    chk("t5_new_word", word_data, 32'hF1F2F3F4);
    step();
    repeat (3) step();

    // 6: 64 random bytes, ready never low two cycles running
    dut_acc.delete();
    sent.delete();
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      sent.push_back(b);
      word_ready = word_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      send(b);
      word_ready = word_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    word_ready = 1;
    repeat (20) step();
    chk("t6_word_count", 32'(dut_acc.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      w = {sent[4*k], sent[4*k+1], sent[4*k+2], sent[4*k+3]};
      if (k < dut_acc.size()) chk("t6_word", dut_acc[k], w);
    end
    chk("t6_no_overrun", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
